// File: rtl/hazard_fwd_ctrl_pkg.sv
// ============================================================================
//  Module   : hazard_fwd_ctrl_pkg
//  Brief    : Shared select codes, Tuse code and shadow-stage record.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_fwd_ctrl_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_M    = 2'b01;
    localparam logic [1:0] FWD_W    = 2'b10;
    localparam logic [1:0] FWD_E    = 2'b11;

    localparam logic [1:0] NO_USE   = 2'd3;

    typedef struct packed {
        logic [4:0] a3;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tnew;
    } stage_rec_t;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_pick.sv
// ============================================================================
//  Module   : hazard_fwd_pick
//  Brief    : Priority encoder choosing the newest ready producer for a source.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_pick
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    input  logic [4:0] w_a3,
    input  logic [2:0] mask,     // {E, M, W} candidates allowed
    output logic [1:0] sel
);

    logic e_hit;
    logic m_hit;
    logic w_hit;

    always_comb begin
        e_hit = mask[2] && (e_a3 != 5'd0) && (e_a3 == src) && (e_tnew == 2'd0);
        m_hit = mask[1] && (m_a3 != 5'd0) && (m_a3 == src) && (m_tnew == 2'd0);
        w_hit = mask[0] && (w_a3 != 5'd0) && (w_a3 == src);

        // Newest producer wins: E over M over W.
        if (e_hit) begin
            sel = FWD_E;
        end else if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Brief    : Shadow-pipeline hazard detector and forwarding-select generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl #(
    parameter logic [1:0] NO_USE = hazard_fwd_ctrl_pkg::NO_USE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_valid,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] tnew_d,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m
);

    import hazard_fwd_ctrl_pkg::*;

    stage_rec_t e_q, e_d;
    logic [4:0] m_a3_q, m_a3_d;
    logic [4:0] m_rt_q, m_rt_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q, w_a3_d;

    logic       stall_rs;
    logic       stall_rt;
    logic [1:0] rt_m_sel;

    function automatic logic src_stall(
        input logic [4:0] idx,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (tuse != NO_USE) && (idx != 5'd0) &&
               (((e_a3 == idx) && (tuse < e_tnew)) ||
                ((m_a3 == idx) && (tuse < m_tnew)));
    endfunction

    always_comb begin
        stall_rs = src_stall(rs_d, tuse_rs_d, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q);
        stall_rt = src_stall(rt_d, tuse_rt_d, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q);
        stall    = d_valid && (stall_rs || stall_rt);
    end

    // A stalled or empty D slot enters E as an all-zero bubble.
    always_comb begin
        e_d = '0;
        if (d_valid && !stall) begin
            e_d.a3   = a3_d;
            e_d.rs   = rs_d;
            e_d.rt   = rt_d;
            e_d.tnew = tnew_d;
        end
        m_a3_d   = e_q.a3;
        m_rt_d   = e_q.rt;
        m_tnew_d = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        w_a3_d   = m_a3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            m_a3_q   <= 5'd0;
            m_rt_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
        end else begin
            e_q      <= e_d;
            m_a3_q   <= m_a3_d;
            m_rt_q   <= m_rt_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
        end
    end

    hazard_fwd_pick u_pick_rs_d (
        .src(rs_d), .e_a3(e_q.a3), .e_tnew(e_q.tnew), .m_a3(m_a3_q),
        .m_tnew(m_tnew_q), .w_a3(w_a3_q), .mask(3'b111), .sel(fwd_rs_d)
    );

    hazard_fwd_pick u_pick_rt_d (
        .src(rt_d), .e_a3(e_q.a3), .e_tnew(e_q.tnew), .m_a3(m_a3_q),
        .m_tnew(m_tnew_q), .w_a3(w_a3_q), .mask(3'b111), .sel(fwd_rt_d)
    );

    hazard_fwd_pick u_pick_rs_e (
        .src(e_q.rs), .e_a3(e_q.a3), .e_tnew(e_q.tnew), .m_a3(m_a3_q),
        .m_tnew(m_tnew_q), .w_a3(w_a3_q), .mask(3'b011), .sel(fwd_rs_e)
    );

    hazard_fwd_pick u_pick_rt_e (
        .src(e_q.rt), .e_a3(e_q.a3), .e_tnew(e_q.tnew), .m_a3(m_a3_q),
        .m_tnew(m_tnew_q), .w_a3(w_a3_q), .mask(3'b011), .sel(fwd_rt_e)
    );

    hazard_fwd_pick u_pick_rt_m (
        .src(m_rt_q), .e_a3(e_q.a3), .e_tnew(e_q.tnew), .m_a3(m_a3_q),
        .m_tnew(m_tnew_q), .w_a3(w_a3_q), .mask(3'b001), .sel(rt_m_sel)
    );

    assign fwd_rt_m = (rt_m_sel == FWD_W);

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Brief    : Self-checking bench for the hazard/forwarding scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid;
    logic [4:0] rs_d, rt_d, a3_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .a3_d(a3_d), .tnew_d(tnew_d), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, a3;
        logic [1:0] trs, trt, tn;
        logic       x_st;
        logic [1:0] x_rsd, x_rtd, x_rse, x_rte;
        logic       x_rtm;
    } vec_t;

    // Model record: instruction that entered E k edges ago sits at hist[k].
    typedef struct {
        int a3, rs, rt, tnew;
    } mrec_t;

    mrec_t hist[3];
    vec_t  tbl[29];

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] rsd,
                           input logic [1:0] rtd, input logic [1:0] rse,
                           input logic [1:0] rte, input logic rtm);
        chk({tag, ".stall"},    {1'b0, stall},    {1'b0, st});
        chk({tag, ".fwd_rs_d"}, fwd_rs_d,         rsd);
        chk({tag, ".fwd_rt_d"}, fwd_rt_d,         rtd);
        chk({tag, ".fwd_rs_e"}, fwd_rs_e,         rse);
        chk({tag, ".fwd_rt_e"}, fwd_rt_e,         rte);
        chk({tag, ".fwd_rt_m"}, {1'b0, fwd_rt_m}, {1'b0, rtm});
    endtask

    function automatic vec_t mk(int v, int rs, int rt, int trs, int trt, int a3, int tn,
                                int st, int rsd, int rtd, int rse, int rte, int rtm);
        vec_t r;
        r.v = 1'(v);   r.rs = 5'(rs);   r.rt = 5'(rt);
        r.trs = 2'(trs); r.trt = 2'(trt); r.a3 = 5'(a3); r.tn = 2'(tn);
        r.x_st = 1'(st); r.x_rsd = 2'(rsd); r.x_rtd = 2'(rtd);
        r.x_rse = 2'(rse); r.x_rte = 2'(rte); r.x_rtm = 1'(rtm);
        return r;
    endfunction

    function automatic int eff_tnew(int k);
        int t;
        t = hist[k].tnew - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic [1:0] m_sel(int src, int k_lo);
        logic [1:0] code[3];
        code[0] = 2'b11; code[1] = 2'b01; code[2] = 2'b10;
        for (int k = k_lo; k < 3; k++)
            if (hist[k].a3 != 0 && hist[k].a3 == src && eff_tnew(k) == 0)
                return code[k];
        return 2'b00;
    endfunction

    function automatic logic m_stall_src(int src, int tuse);
        if (tuse == 3 || src == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (hist[k].a3 == src && tuse < eff_tnew(k)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    endtask

    // Compare against the model for the current inputs, then advance the model.
    task automatic model_step(input string tag);
        logic st, rtm;
        mrec_t nw;
        st  = d_valid && (m_stall_src(int'(rs_d), int'(tuse_rs_d)) ||
                          m_stall_src(int'(rt_d), int'(tuse_rt_d)));
        rtm = (hist[2].a3 != 0) && (hist[2].a3 == hist[1].rt);
        chk_all(tag, st, m_sel(int'(rs_d), 0), m_sel(int'(rt_d), 0),
                m_sel(hist[0].rs, 1), m_sel(hist[0].rt, 1), rtm);
        if (st || !d_valid) nw = '{0, 0, 0, 0};
        else nw = '{int'(a3_d), int'(rs_d), int'(rt_d), int'(tnew_d)};
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = nw;
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input int trs,
                         input int trt, input int a3, input int tn);
        d_valid = v; rs_d = 5'(rs); rt_d = 5'(rt);
        tuse_rs_d = 2'(trs); tuse_rt_d = 2'(trt); a3_d = 5'(a3); tnew_d = 2'(tn);
    endtask

    initial begin
        // Idle rows are bubbles that also let the shadow pipe drain.
        tbl[0]  = mk(1, 0, 0, 3, 3, 8, 1,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 3, 3, 9, 2,   0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 9, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 9, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 9, 3, 0, 0, 0,   0, 0, 2, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 3, 3, 31, 0,  0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 31, 0, 0, 3, 0, 0,  0, 3, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 3, 3, 5, 2,   0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 5, 3, 2, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 3, 3, 0, 2,   0, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 0, 0, 3, 3, 4, 0,   0, 0, 0, 0, 0, 0);
        tbl[24] = mk(1, 0, 0, 3, 3, 4, 0,   0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 4, 4, 0, 0, 0, 0,   0, 3, 3, 0, 0, 0);
        tbl[26] = mk(0, 4, 0, 0, 3, 0, 0,   0, 1, 0, 1, 1, 0);
        tbl[27] = mk(0, 4, 0, 0, 3, 0, 0,   0, 2, 0, 0, 0, 1);
        tbl[28] = mk(0, 0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(1'b0, 0, 0, 3, 3, 0, 0);
        model_clear();
        repeat (2) @(negedge clk);
        #1 chk_all("reset_low", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_all("reset_rel", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].trs),
                  int'(tbl[i].trt), int'(tbl[i].a3), int'(tbl[i].tn));
            #1 chk_all($sformatf("vec%0d", i), tbl[i].x_st, tbl[i].x_rsd,
                       tbl[i].x_rtd, tbl[i].x_rse, tbl[i].x_rte, tbl[i].x_rtm);
        end

        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 3, 3, 0, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drive(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
            #1 model_step($sformatf("rnd%0d", i));
        end

        // Reset asserted while a load-use stall is in progress.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 3, 3, 0, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 9, 2);
        #1 model_step("ms_load");
        @(negedge clk);
        drive(1'b1, 0, 9, 3, 0, 0, 0);
        #1 model_step("ms_use");
        chk("ms_stall_on", {1'b0, stall}, 2'b01);
        #2 rst_n = 1'b0;
        #1 chk_all("ms_async_rst", 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 model_step($sformatf("ms_after%0d", i));
            chk($sformatf("ms_no_stale%0d", i), fwd_rt_d, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
